// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU's instruction-fetch and data-memory request ports onto one
// physical memory port, returning a one-cycle resp plus read data to the requester.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned WIDTH        = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [WIDTH-1:0] i_mem_address,
    input  logic [WIDTH-1:0] i_mem_wdata,
    input  logic [1:0]       i_mem_byte_enable,
    output logic             i_mem_resp,
    output logic [WIDTH-1:0] i_mem_rdata,

    input  logic             d_mem_read,
    input  logic             d_mem_write,
    input  logic [WIDTH-1:0] d_mem_address,
    input  logic [WIDTH-1:0] d_mem_wdata,
    input  logic [1:0]       d_mem_byte_enable,
    output logic             d_mem_resp,
    output logic [WIDTH-1:0] d_mem_rdata,

    output logic             pmem_read,
    output logic             pmem_write,
    output logic [WIDTH-1:0] pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    output logic [1:0]       pmem_byte_enable,
    input  logic             pmem_resp,
    input  logic [WIDTH-1:0] pmem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t           r_state;
    state_t           w_next;
    logic             r_write;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [1:0]       r_be;
    logic [WIDTH-1:0] r_i_rdata;
    logic [WIDTH-1:0] r_d_rdata;
    logic [3:0]       r_starve_cnt;
    logic [3:0]       w_starve_next;
    logic             w_i_req;
    logic             w_d_req;
    logic             w_grant_i;
    logic             w_grant_d;

    assign w_i_req = i_mem_read | i_mem_write;
    assign w_d_req = d_mem_read | d_mem_write;

    assign pmem_address     = r_addr;
    assign pmem_wdata       = r_wdata;
    assign pmem_byte_enable = r_be;
    assign i_mem_rdata      = r_i_rdata;
    assign d_mem_rdata      = r_d_rdata;

    always_comb begin
        w_next        = r_state;
        w_starve_next = r_starve_cnt;
        w_grant_i     = 1'b0;
        w_grant_d     = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        i_mem_resp    = 1'b0;
        d_mem_resp    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // D wins ties until I has been passed over STARVE_LIMIT times
                if (w_d_req && !(w_i_req && r_starve_cnt == LIMIT)) begin
                    w_grant_d = 1'b1;
                    w_next    = BUSY_D;
                    if (w_i_req && r_starve_cnt < LIMIT) begin
                        w_starve_next = r_starve_cnt + 4'd1;
                    end
                end else if (w_i_req) begin
                    w_grant_i     = 1'b1;
                    w_next        = BUSY_I;
                    w_starve_next = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                pmem_read  = ~r_write;
                pmem_write = r_write;
                if (pmem_resp) begin
                    w_next = (r_state == BUSY_I) ? RESP_I : RESP_D;
                end
            end
            RESP_I: begin
                i_mem_resp = 1'b1;
                w_next     = IDLE;
            end
            RESP_D: begin
                d_mem_resp = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_next;
            r_starve_cnt <= w_starve_next;
            if (w_grant_i) begin
                r_write <= i_mem_write;
                r_addr  <= i_mem_address;
                r_wdata <= i_mem_wdata;
                r_be    <= i_mem_byte_enable;
            end else if (w_grant_d) begin
                r_write <= d_mem_write;
                r_addr  <= d_mem_address;
                r_wdata <= d_mem_wdata;
                r_be    <= d_mem_byte_enable;
            end
            if (r_state == BUSY_I && pmem_resp && !r_write) begin
                r_i_rdata <= pmem_rdata;
            end
            if (r_state == BUSY_D && pmem_resp && !r_write) begin
                r_d_rdata <= pmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: two CPU-side agents, a
// variable-latency memory, and a transaction-level reference of the grant rules.
module tb_mem_port_arbiter;
    localparam int LIMIT = 2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } req_t;

    typedef enum {PH_IDLE, PH_BUSY, PH_RESP} phase_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_rd[2];
    logic        a_wr[2];
    logic [15:0] a_addr[2];
    logic [15:0] a_wdata[2];
    logic [1:0]  a_be[2];
    logic        i_mem_resp, d_mem_resp;
    logic [15:0] i_mem_rdata, d_mem_rdata;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
    logic [1:0]  pmem_byte_enable;

    // stimulus control
    bit          en[2];
    bit          kick[2];
    req_t        kick_req[2];
    bit          nogap;
    bit          spur_en;
    int unsigned scramble_pct;
    int          mem_delay;
    bit          a_busy[2];
    int unsigned issued[2];
    int unsigned done[2];

    // scoreboard
    req_t        q_i[$];
    req_t        q_d[$];
    int          grants[$];
    int          inflight = -1;
    int unsigned n_total = 0;
    int unsigned n_pass = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .i_mem_read(a_rd[0]), .i_mem_write(a_wr[0]), .i_mem_address(a_addr[0]),
        .i_mem_wdata(a_wdata[0]), .i_mem_byte_enable(a_be[0]),
        .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
        .d_mem_read(a_rd[1]), .d_mem_write(a_wr[1]), .d_mem_address(a_addr[1]),
        .d_mem_wdata(a_wdata[1]), .d_mem_byte_enable(a_be[1]),
        .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    task automatic chk_txn(input string tag, input req_t r);
        chk({tag, "_write"}, pmem_write, r.wr);
        chk({tag, "_read"}, pmem_read, !r.wr);
        chk({tag, "_addr"}, pmem_address, r.addr);
        chk({tag, "_wdata"}, pmem_wdata, r.wdata);
        chk({tag, "_be"}, pmem_byte_enable, r.be);
    endtask

    // CPU-side agents: hold a request until its resp, optionally disturb inputs while in flight
    initial begin
        req_t        r;
        int unsigned op;
        logic        resp_p;
        for (int p = 0; p < 2; p++) begin
            a_rd[p] = 1'b0; a_wr[p] = 1'b0; a_addr[p] = '0; a_wdata[p] = '0; a_be[p] = '0;
        end
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                resp_p = (p == 0) ? i_mem_resp : d_mem_resp;
                if (reset) begin
                    a_busy[p] = 1'b0; a_rd[p] = 1'b0; a_wr[p] = 1'b0;
                end else begin
                    if (a_busy[p] && resp_p) begin
                        a_busy[p] = 1'b0; a_rd[p] = 1'b0; a_wr[p] = 1'b0;
                        done[p]++;
                    end
                    if (!a_busy[p] && (kick[p] || (en[p] && (nogap || $urandom_range(0, 3) == 0)))) begin
                        if (kick[p]) begin
                            r = kick_req[p];
                            kick[p] = 1'b0;
                        end else begin
                            op = $urandom_range(0, 2);
                            r.rd = (op != 1); r.wr = (op != 0);
                            r.addr = 16'($urandom); r.wdata = 16'($urandom); r.be = 2'($urandom);
                        end
                        a_rd[p] = r.rd; a_wr[p] = r.wr; a_addr[p] = r.addr;
                        a_wdata[p] = r.wdata; a_be[p] = r.be;
                        if (p == 0) q_i.push_back(r); else q_d.push_back(r);
                        a_busy[p] = 1'b1;
                        issued[p]++;
                    end else if (a_busy[p] && inflight == p && $urandom_range(0, 99) < scramble_pct) begin
                        a_addr[p] = 16'($urandom); a_wdata[p] = 16'($urandom); a_be[p] = 2'($urandom);
                    end
                end
            end
        end
    end

    // physical memory: responds after mem_delay cycles (random when negative), spurious resps when idle
    initial begin
        bit mem_active;
        int mem_cnt;
        mem_active = 1'b0; mem_cnt = 0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_read || pmem_write) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    mem_cnt = (mem_delay < 0) ? int'($urandom_range(0, 4)) : mem_delay;
                end
                if (mem_cnt == 0) begin
                    pmem_resp = 1'b1; pmem_rdata = memf(pmem_address); mem_active = 1'b0;
                end else begin
                    pmem_resp = 1'b0; pmem_rdata = 16'($urandom); mem_cnt--;
                end
            end else begin
                mem_active = 1'b0;
                pmem_resp = spur_en && ($urandom_range(0, 5) == 0);
                pmem_rdata = 16'($urandom);
            end
        end
    end

    // monitor: ph is the arbiter phase during the cycle that just ended at this edge
    initial begin
        phase_t      ph;
        req_t        cur;
        int          g;
        int          m_starve;
        logic        reqi, reqd;
        logic [15:0] exp_rd[2];
        ph = PH_IDLE; m_starve = 0; g = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        cur = '{rd: 1'b0, wr: 1'b0, addr: '0, wdata: '0, be: '0};
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                chk("rst_i_resp", i_mem_resp, 0);
                chk("rst_d_resp", d_mem_resp, 0);
                chk("rst_pmem_read", pmem_read, 0);
                chk("rst_pmem_write", pmem_write, 0);
                chk("rst_pmem_addr", pmem_address, 0);
                chk("rst_pmem_wdata", pmem_wdata, 0);
                chk("rst_pmem_be", pmem_byte_enable, 0);
                chk("rst_i_rdata", i_mem_rdata, 0);
                chk("rst_d_rdata", d_mem_rdata, 0);
                ph = PH_IDLE; inflight = -1; m_starve = 0;
                exp_rd[0] = '0; exp_rd[1] = '0;
                q_i.delete(); q_d.delete();
            end else begin
                reqi = a_rd[0] | a_wr[0];
                reqd = a_rd[1] | a_wr[1];
                chk("strobe_excl", pmem_read & pmem_write, 0);
                case (ph)
                    PH_IDLE: begin
                        chk("idle_i_resp", i_mem_resp, 0);
                        chk("idle_d_resp", d_mem_resp, 0);
                        if (reqi || reqd) begin
                            g = (reqd && !(reqi && m_starve == LIMIT)) ? 1 : 0;
                            if (g == 1 && reqi) m_starve = (m_starve < LIMIT) ? m_starve + 1 : m_starve;
                            else if (g == 0) m_starve = 0;
                            if (g == 0) begin
                                chk("sb_has_req_i", q_i.size(), 1);
                                if (q_i.size() > 0) cur = q_i.pop_front();
                            end else begin
                                chk("sb_has_req_d", q_d.size(), 1);
                                if (q_d.size() > 0) cur = q_d.pop_front();
                            end
                            inflight = g;
                            grants.push_back(g);
                            chk_txn(g == 0 ? "grant_i" : "grant_d", cur);
                            ph = PH_BUSY;
                        end else begin
                            chk("idle_strobe", pmem_read | pmem_write, 0);
                        end
                    end
                    PH_BUSY: begin
                        if (pmem_resp) begin
                            chk("resp_i", i_mem_resp, inflight == 0);
                            chk("resp_d", d_mem_resp, inflight == 1);
                            chk("resp_strobe", pmem_read | pmem_write, 0);
                            if (!cur.wr) exp_rd[inflight] = memf(cur.addr);
                            inflight = -1;
                            ph = PH_RESP;
                        end else begin
                            chk("busy_i_resp", i_mem_resp, 0);
                            chk("busy_d_resp", d_mem_resp, 0);
                            chk_txn("hold", cur);
                        end
                    end
                    default: begin
                        chk("post_i_resp", i_mem_resp, 0);
                        chk("post_d_resp", d_mem_resp, 0);
                        chk("post_strobe", pmem_read | pmem_write, 0);
                        ph = PH_IDLE;
                    end
                endcase
                chk("i_rdata", i_mem_rdata, exp_rd[0]);
                chk("d_rdata", d_mem_rdata, exp_rd[1]);
            end
        end
    end

    task automatic wait_idle(input int unsigned max_cycles);
        for (int unsigned c = 0; c < max_cycles; c++) begin
            @(posedge clk);
            if (!a_busy[0] && !a_busy[1] && !kick[0] && !kick[1]) break;
        end
        chk("drain", {kick[0], kick[1], a_busy[0], a_busy[1]}, 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int unsigned d_done_before;
        int          exp_order[6];
        exp_order = '{1, 1, 0, 1, 1, 0};
        en[0] = 0; en[1] = 0; kick[0] = 0; kick[1] = 0;
        nogap = 0; spur_en = 0; scramble_pct = 0; mem_delay = -1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        @(posedge clk);
        mem_delay = 3;
        kick_req[0] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0040, wdata: 16'h0000, be: 2'b11};
        kick[0] = 1'b1;
        wait_idle(50);

        scramble_pct = 100;
        kick_req[1] = '{rd: 1'b0, wr: 1'b1, addr: 16'h0101, wdata: 16'h00AB, be: 2'b10};
        kick[1] = 1'b1;
        wait_idle(50);

        kick_req[1] = '{rd: 1'b1, wr: 1'b1, addr: 16'h0202, wdata: 16'h5555, be: 2'b01};
        kick[1] = 1'b1;
        wait_idle(50);

        spur_en = 1;
        repeat (20) @(posedge clk);

        mem_delay = -1; scramble_pct = 30;
        en[0] = 1; en[1] = 1;
        repeat (1500) @(posedge clk);
        en[0] = 0; en[1] = 0;
        wait_idle(100);

        // abort a D read in flight with reset
        mem_delay = 1000; spur_en = 0;
        d_done_before = done[1];
        kick_req[1] = '{rd: 1'b1, wr: 1'b0, addr: 16'h0777, wdata: 16'h0000, be: 2'b11};
        kick[1] = 1'b1;
        for (int c = 0; c < 20 && inflight != 1; c++) @(posedge clk);
        chk("abort_granted", inflight, 1);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);
        chk("abort_no_resp", done[1] - d_done_before, 0);
        chk("abort_dropped", a_busy[1], 0);

        // continuous contention with immediate memory
        mem_delay = 0; scramble_pct = 0;
        grants.delete();
        nogap = 1; en[0] = 1; en[1] = 1;
        for (int c = 0; c < 100 && grants.size() < 6; c++) @(posedge clk);
        en[0] = 0; en[1] = 0; nogap = 0;
        chk("starve_grants_seen", grants.size() >= 6, 1);
        for (int k = 0; k < 6 && k < grants.size(); k++) chk("starve_order", grants[k], exp_order[k]);
        wait_idle(50);

        chk("sb_left_i", q_i.size(), 0);
        chk("sb_left_d", q_d.size(), 0);
        chk("done_i", done[0], issued[0]);
        chk("done_d", done[1], issued[1] - 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at %0t: got timeout, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
